// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and frame sizing.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Total serial-line cycles for one character frame.
    function automatic int frame_cycles(input int cpb, input int data_bits,
                                        input int parity, input int stop_bits);
        return (1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits) * cpb;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, pointers are.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with configurable frame format; frames are
// emitted back-to-back while the FIFO holds data.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               tx_start,
    input  logic [DATA_BITS-1:0]               tx_data,
    output logic                               tx_ready,
    output logic                               tx_overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               tx,
    output logic                               tx_busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = 4;

    tx_state_e            state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ovf_q;

    logic                 fifo_full, fifo_empty, pop, load, baud_last;
    logic [DATA_BITS-1:0] head;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (tx_start),
        .wdata_i (tx_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign tx_ready    = !fifo_full;
    assign tx_overflow = ovf_q;
    assign tx          = tx_q;
    assign tx_busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign baud_last   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                load   = !fifo_empty;
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q ^ shift_q[0];
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        load    = !fifo_empty;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Odd parity seeds the accumulator with 1 so the XOR chain inverts.
        if (load) begin
            state_d = ST_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = head;
            par_d   = (PARITY == PARITY_ODD);
            tx_d    = 1'b0;
        end
    end
    assign pop = load;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ovf_q   <= tx_start && fifo_full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter configurations (8N1, 8E1, 8O1, 7N2) against a frame-level
// reference: a character queue plus per-frame bit lists.
module tb_uart_tx_fifo;
    localparam int NI    = 4;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int DB_T  [NI] = '{8, 8, 8, 7};
    localparam int PAR_T [NI] = '{0, 2, 1, 0};
    localparam int SB_T  [NI] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_w [NI];
    logic [8:0] data_w  [NI];
    logic       rdy_w   [NI];
    logic       ovf_w   [NI];
    logic [2:0] cnt_w   [NI];
    logic       tx_w    [NI];
    logic       busy_w  [NI];
    logic [8:0] bq      [8];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_fifo #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB_T[g]),
            .PARITY       (PAR_T[g]),
            .STOP_BITS    (SB_T[g]),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .tx_start    (start_w[g]),
            .tx_data     (data_w[g][DB_T[g]-1:0]),
            .tx_ready    (rdy_w[g]),
            .tx_overflow (ovf_w[g]),
            .fifo_count  (cnt_w[g]),
            .tx          (tx_w[g]),
            .tx_busy     (busy_w[g])
        );
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int frame_len(input int k);
        return (1 + DB_T[k] + ((PAR_T[k] != 0) ? 1 : 0) + SB_T[k]) * CPB;
    endfunction

    // Line level of bit cell idx of the frame carrying character b.
    function automatic logic exp_bit(input int k, input logic [8:0] b, input int idx);
        logic p;
        if (idx == 0) return 1'b0;
        if (idx <= DB_T[k]) return b[idx-1];
        if (PAR_T[k] != 0 && idx == DB_T[k] + 1) begin
            p = 1'b0;
            for (int i = 0; i < DB_T[k]; i++) p ^= b[i];
            return (PAR_T[k] == 2) ? p : ~p;
        end
        return 1'b1;
    endfunction

    // Push bq[0..nb-1] on consecutive cycles into instance k and check every
    // cycle for `steps` cycles, starting with the edge that sees the first push.
    task automatic run_scn(input int k, input int nb, input int steps);
        logic [8:0] q[$];
        logic [8:0] cur_b = '0;
        logic [8:0] mask;
        int   cur_p = -100000;
        int   f = frame_len(k);
        logic push_req, full, pop, ovf_e, tx_e, busy_e;
        mask = 9'((1 << DB_T[k]) - 1);
        for (int j = 0; j < steps; j++) begin
            push_req   = (j < nb);
            start_w[k] = push_req;
            data_w[k]  = push_req ? (bq[j] & mask) : 9'h0;
            full = (q.size() == DEPTH);
            pop  = (q.size() > 0) && (j >= cur_p + f);
            tick();
            if (pop) begin
                cur_b = q.pop_front();
                cur_p = j;
            end
            ovf_e = push_req && full;
            if (push_req && !full) q.push_back(bq[j] & mask);
            tx_e   = (j >= cur_p && j < cur_p + f) ? exp_bit(k, cur_b, (j - cur_p) / CPB) : 1'b1;
            busy_e = (j < cur_p + f) || (q.size() > 0);
            chk($sformatf("tx[%0d]@%0d", k, j), int'(tx_w[k]), int'(tx_e));
            chk($sformatf("cnt[%0d]@%0d", k, j), int'(cnt_w[k]), q.size());
            chk($sformatf("rdy[%0d]@%0d", k, j), int'(rdy_w[k]), int'(q.size() < DEPTH));
            chk($sformatf("ovf[%0d]@%0d", k, j), int'(ovf_w[k]), int'(ovf_e));
            chk($sformatf("busy[%0d]@%0d", k, j), int'(busy_w[k]), int'(busy_e));
        end
        start_w[k] = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_tx%0d", tag, k), int'(tx_w[k]), 1);
            chk($sformatf("%s_busy%0d", tag, k), int'(busy_w[k]), 0);
            chk($sformatf("%s_rdy%0d", tag, k), int'(rdy_w[k]), 1);
            chk($sformatf("%s_cnt%0d", tag, k), int'(cnt_w[k]), 0);
            chk($sformatf("%s_ovf%0d", tag, k), int'(ovf_w[k]), 0);
        end
    endtask

    initial begin
        int k, nb, f;
        for (int i = 0; i < NI; i++) begin
            start_w[i] = 1'b0;
            data_w[i]  = '0;
        end
        repeat (3) tick();
        chk_idle("rst");
        reset_n = 1'b1;
        repeat (2) tick();

        // Single characters on every format.
        bq[0] = 9'hA5;
        run_scn(0, 1, 180);
        run_scn(1, 1, 200);
        run_scn(2, 1, 200);
        bq[0] = 9'h55;
        run_scn(3, 1, 180);

        // Back-to-back frames, then overflow on a full FIFO.
        bq[0] = 9'h11; bq[1] = 9'h22; bq[2] = 9'h33;
        run_scn(0, 3, 3 * 160 + 20);
        for (int i = 0; i < 6; i++) bq[i] = 9'((i + 1) * 16 + i + 1);
        run_scn(0, 6, 5 * 160 + 20);

        // Randomised characters and burst lengths across all formats.
        for (int r = 0; r < 8; r++) begin
            k  = int'($urandom_range(0, NI - 1));
            nb = int'($urandom_range(1, 6));
            f  = frame_len(k);
            for (int i = 0; i < 8; i++) bq[i] = 9'($urandom);
            run_scn(k, nb, ((nb > 5) ? 5 : nb) * f + 20);
        end

        // Reset in mid-DATA of the first of two queued characters.
        bq[0] = 9'h11; bq[1] = 9'h22;
        run_scn(0, 2, 70);
        #1 reset_n = 1'b0;
        #1 chk_idle("midrst");
        #1 reset_n = 1'b1;
        run_scn(0, 0, 200);
        bq[0] = 9'h3C;
        run_scn(0, 1, 180);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0t exp=<2000000", $time);
        $fatal(1, "timeout");
    end

endmodule
